// File: rtl/if_fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_REQ  = 2'b01,
        IF_HOLD = 2'b10
    } if_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_hold_buf.sv
// One-entry pc+inst holding register that parks a fetched word while decode is stalled.
module if_hold_buf
    import if_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [INST_W-1:0] load_inst,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] inst
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Payload carries no control meaning on its own, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (load) begin
            pc   <= load_pc;
            inst <= load_inst;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, imem req/ack handshake, single-delay-slot
// redirect handling and a registered pc/inst/valid interface toward decode.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_id_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o
);

    if_state_e         state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] redir_target;
    logic              redir_pending;

    logic              id_accept;
    logic              redir_accept;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              buf_load;
    logic              buf_clear;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_pc;
    logic [INST_W-1:0] buf_inst;

    assign id_accept    = !stall_id_i || !id_valid_o;
    assign redir_accept = branch_flag_i && id_valid_o && !stall_id_i;

    // A pending target wins: a branch sitting in a delay slot must not override it.
    assign redir_pc = redir_pending ? redir_target : word_align(branch_target_address_i);
    assign next_pc  = (redir_pending || redir_accept) ? redir_pc : pc + 32'd4;

    assign buf_load  = (state == IF_REQ) && imem_ack_i && !id_accept;
    assign buf_clear = (state == IF_HOLD) && id_accept;

    assign imem_req_o  = (state == IF_REQ);
    assign imem_addr_o = pc;

    if_hold_buf u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_pc   (pc),
        .load_inst (imem_rdata_i),
        .valid     (buf_valid),
        .pc        (buf_pc),
        .inst      (buf_inst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IF_IDLE;
            pc            <= RESET_PC;
            redir_pending <= 1'b0;
            id_valid_o    <= 1'b0;
            id_inst_o     <= ZERO_WORD;
            id_pc_o       <= '0;
        end else begin
            case (state)
                IF_IDLE: begin
                    state <= IF_REQ;
                end
                IF_REQ: begin
                    if (imem_ack_i) begin
                        pc            <= next_pc;
                        redir_pending <= 1'b0;
                        if (id_accept) begin
                            id_pc_o    <= pc;
                            id_inst_o  <= imem_rdata_i;
                            id_valid_o <= 1'b1;
                        end else begin
                            state <= IF_HOLD;
                        end
                    end else begin
                        // Delay-slot word still outstanding: remember where to go after it.
                        if (redir_accept && !redir_pending) begin
                            redir_pending <= 1'b1;
                            redir_target  <= word_align(branch_target_address_i);
                        end
                        if (id_accept) begin
                            id_valid_o <= 1'b0;
                            id_inst_o  <= ZERO_WORD;
                        end
                    end
                end
                IF_HOLD: begin
                    if (id_accept) begin
                        if (buf_valid) begin
                            id_pc_o    <= buf_pc;
                            id_inst_o  <= buf_inst;
                            id_valid_o <= 1'b1;
                        end
                        // Buffer already holds the delay slot and pc is unrequested.
                        if (redir_accept) begin
                            pc <= redir_pc;
                        end
                        state <= IF_REQ;
                    end
                end
                default: begin
                    state <= IF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized stall/ack/branch traffic
// checked against an instruction-stream model of the decode-visible sequence.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_id_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    int vectors = 0;
    int miscompares = 0;

    int unsigned lat = 0;
    int unsigned waited = 0;
    logic        rand_mode = 1'b0;
    logic        rand_ack = 1'b0;
    logic        spurious = 1'b0;

    // Model state shared with the driver so branches are never placed in a delay slot.
    logic [31:0] m_exp = 32'h0;
    logic [31:0] m_tgt = 32'h0;
    logic        m_slot = 1'b0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_id_i              (stall_id_i),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .imem_req_o              (imem_req_o),
        .imem_addr_o             (imem_addr_o),
        .imem_ack_i              (imem_ack_i),
        .imem_rdata_i            (imem_rdata_i),
        .id_pc_o                 (id_pc_o),
        .id_inst_o               (id_inst_o),
        .id_valid_o              (id_valid_o)
    );

    // Combinational memory: instruction word equals its address; junk when no request.
    assign imem_ack_i   = imem_req_o ? (rand_mode ? rand_ack : (waited >= lat)) : spurious;
    assign imem_rdata_i = imem_req_o ? imem_addr_o : ~imem_addr_o;

    always @(posedge clk) begin
        if (rst || !imem_req_o || imem_ack_i) waited <= 0;
        else waited <= waited + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the expected decode instruction stream.
    initial begin : compare
        logic [31:0] prev_addr;
        logic        prev_wait;
        int          idle;
        prev_addr = 32'h0;
        prev_wait = 1'b0;
        idle = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_exp = 32'h0;
                m_slot = 1'b0;
                prev_wait = 1'b0;
                idle = 0;
            end else begin
                if (prev_wait) begin
                    chk("req_held", {31'd0, imem_req_o}, 32'd1);
                    chk("addr_held", imem_addr_o, prev_addr);
                end
                if (imem_req_o) chk("addr_align", {30'd0, imem_addr_o[1:0]}, 32'd0);
                if (id_valid_o) begin
                    chk("id_pc", id_pc_o, m_exp);
                    chk("id_inst", id_inst_o, m_exp);
                end else begin
                    chk("id_inst_bubble", id_inst_o, 32'h0);
                end
                prev_wait = imem_req_o && !imem_ack_i;
                prev_addr = imem_addr_o;
                if (id_valid_o && !stall_id_i) begin
                    idle = 0;
                    if (m_slot) begin
                        m_exp  = m_tgt;
                        m_slot = 1'b0;
                    end else if (branch_flag_i) begin
                        m_exp  = m_exp + 32'd4;
                        m_tgt  = {branch_target_address_i[31:2], 2'b00};
                        m_slot = 1'b1;
                    end else begin
                        m_exp = m_exp + 32'd4;
                    end
                end else begin
                    idle++;
                    if (idle > 400) begin
                        chk("progress", 32'(idle), 32'd0);
                        idle = 0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] t;
        // Reset values
        repeat (3) tick();
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_inst", id_inst_o, 32'h0);
        rst = 1'b0;

        // Scenario 1: ack=req streaming
        tick();
        chk("s1_req", {31'd0, imem_req_o}, 32'd1);
        chk("s1_addr0", imem_addr_o, 32'h0);
        chk("s1_valid0", {31'd0, id_valid_o}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("s1_addr", imem_addr_o, 32'(4 * (k + 1)));
            chk("s1_idpc", id_pc_o, 32'(4 * k));
            chk("s1_valid", {31'd0, id_valid_o}, 32'd1);
        end

        // Scenario 3: stall at the ack of 0x0C
        stall_id_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s3_req_hold", {31'd0, imem_req_o}, 32'd0);
            chk("s3_idpc_hold", id_pc_o, 32'h08);
        end
        stall_id_i = 1'b0;
        tick();
        chk("s3_idpc_c", id_pc_o, 32'h0C);
        chk("s3_addr_10", imem_addr_o, 32'h10);
        tick();
        chk("s3_idpc_10", id_pc_o, 32'h10);

        // Scenario 4: branch on 0x10 to 0x103
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h103;
        tick();
        branch_flag_i = 1'b0;
        chk("s4_idpc_slot", id_pc_o, 32'h14);
        chk("s4_addr_tgt", imem_addr_o, 32'h100);
        tick();
        chk("s4_idpc_tgt", id_pc_o, 32'h100);
        chk("s4_addr_next", imem_addr_o, 32'h104);

        // Scenario 2: three-cycle ack latency
        lat = 2;
        tick();
        chk("s2_addr_a", imem_addr_o, 32'h104);
        chk("s2_bubble_a", {31'd0, id_valid_o}, 32'd0);
        chk("s2_idpc_keep", id_pc_o, 32'h100);
        tick();
        chk("s2_addr_b", imem_addr_o, 32'h104);
        chk("s2_bubble_b", {31'd0, id_valid_o}, 32'd0);
        tick();
        chk("s2_idpc", id_pc_o, 32'h104);
        chk("s2_valid", {31'd0, id_valid_o}, 32'd1);
        chk("s2_addr_c", imem_addr_o, 32'h108);

        // Scenario 5: branch on 0x104 while its delay slot is still outstanding
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h203;
        tick();
        branch_flag_i = 1'b0;
        chk("s5_bubble", {31'd0, id_valid_o}, 32'd0);
        chk("s5_addr_slot", imem_addr_o, 32'h108);
        tick();
        chk("s5_addr_slot2", imem_addr_o, 32'h108);
        tick();
        chk("s5_idpc_slot", id_pc_o, 32'h108);
        chk("s5_addr_tgt", imem_addr_o, 32'h200);
        lat = 0;
        tick();
        chk("s5_idpc_tgt", id_pc_o, 32'h200);

        // Scenario 6: reset while a request is being acked
        rst = 1'b1;
        tick();
        chk("s6_req", {31'd0, imem_req_o}, 32'd0);
        chk("s6_valid", {31'd0, id_valid_o}, 32'd0);
        chk("s6_pc", id_pc_o, 32'h0);
        chk("s6_inst", id_inst_o, 32'h0);
        rst = 1'b0;
        tick();
        chk("s6_addr", imem_addr_o, 32'h0);
        tick();
        chk("s6_idpc", id_pc_o, 32'h0);
        chk("s6_valid1", {31'd0, id_valid_o}, 32'd1);

        // Randomized traffic
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst        = ($urandom_range(0, 599) == 0);
            stall_id_i = ($urandom_range(0, 3) == 0);
            rand_ack   = ($urandom_range(0, 9) < 6);
            spurious   = $urandom_range(0, 1) == 1;
            if (!m_slot && $urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0: t = $urandom;
                    1: t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    2: t = 32'($urandom_range(0, 255));
                    default: t = 32'h0000_1000 + 32'($urandom_range(0, 63));
                endcase
                branch_flag_i = 1'b1;
                branch_target_address_i = t;
            end else begin
                branch_flag_i = 1'b0;
            end
        end
        rst = 1'b0;
        stall_id_i = 1'b0;
        branch_flag_i = 1'b0;
        rand_mode = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
